// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: op encodings, FSM states and the
// packed pipeline-latch layouts exchanged with AGEX, DE and WB.
package mem_stage_pkg;

   localparam int XLEN        = 32;
   localparam int REG_BITS    = 5;
   localparam int OP_BITS     = 6;
   localparam int CANARY_BITS = 8;

   typedef enum logic [OP_BITS-1:0] {
      OP_NOP = 6'h00,
      OP_ADD = 6'h01,
      OP_SUB = 6'h02,
      OP_AND = 6'h03,
      OP_OR  = 6'h04,
      OP_LB  = 6'h10,
      OP_LH  = 6'h11,
      OP_LW  = 6'h12,
      OP_LBU = 6'h13,
      OP_LHU = 6'h14,
      OP_SB  = 6'h18,
      OP_SH  = 6'h19,
      OP_SW  = 6'h1A
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RSP  = 2'd2
   } mem_state_e;

   typedef struct packed {
      logic [XLEN-1:0]        inst;
      logic [XLEN-1:0]        pc;
      op_e                    op;
      logic [XLEN-1:0]        inst_count;
      logic [REG_BITS-1:0]    reg_dest;
      logic [XLEN-1:0]        result;
      logic [XLEN-1:0]        store_data;
      logic                   wr_reg;
      logic [CANARY_BITS-1:0] bus_canary;
   } agex_latch_t;

   typedef struct packed {
      logic [XLEN-1:0]        inst;
      logic [XLEN-1:0]        pc;
      op_e                    op;
      logic [XLEN-1:0]        inst_count;
      logic [REG_BITS-1:0]    reg_dest;
      logic [XLEN-1:0]        wb_data;
      logic                   wr_reg;
      logic                   misalign;
      logic [CANARY_BITS-1:0] bus_canary;
   } mem_latch_t;

   typedef struct packed {
      logic                stall;
      logic                fwd_valid;
      logic [REG_BITS-1:0] reg_dest;
      logic [XLEN-1:0]     fwd_data;
   } mem_to_agex_t;

   typedef struct packed {
      logic                mem_busy;
      logic [REG_BITS-1:0] reg_dest;
      logic                wr_reg;
   } mem_to_de_t;

   localparam int AGEX_LATCH_WIDTH       = $bits(agex_latch_t);
   localparam int MEM_LATCH_WIDTH        = $bits(mem_latch_t);
   localparam int FROM_MEM_TO_AGEX_WIDTH = $bits(mem_to_agex_t);
   localparam int FROM_MEM_TO_DE_WIDTH   = $bits(mem_to_de_t);

   function automatic logic is_load(op_e op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   endfunction

   function automatic logic is_store(op_e op);
      return op inside {OP_SB, OP_SH, OP_SW};
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory stage: store byte enables and lane
// replication, load extraction with sign/zero extension, alignment check.
module mem_lane_align
   import mem_stage_pkg::*;
(
   input  logic [OP_BITS-1:0] op,
   input  logic [1:0]         addr,
   input  logic [XLEN-1:0]    store_data,
   input  logic [XLEN-1:0]    rdata,
   output logic [3:0]         be,
   output logic [XLEN-1:0]    wdata,
   output logic [XLEN-1:0]    load_data,
   output logic               misalign
);

   op_e             op_v;
   logic [XLEN-1:0] byte_word;
   logic [XLEN-1:0] half_word;

   assign op_v      = op_e'(op);
   assign byte_word = rdata >> {addr, 3'b000};
   assign half_word = rdata >> {addr[1], 4'b0000};

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      be        = 4'b0000;
      wdata     = '0;
      load_data = '0;
      misalign  = 1'b0;
      unique case (op_v)
         OP_SB: begin
            be    = 4'b0001 << addr;
            wdata = {4{store_data[7:0]}};
         end
         OP_SH: begin
            misalign = addr[0];
            be       = 4'b0011 << {addr[1], 1'b0};
            wdata    = {2{store_data[15:0]}};
         end
         OP_SW: begin
            misalign = (addr != 2'b00);
            be       = 4'b1111;
            wdata    = store_data;
         end
         OP_LB:  load_data = {{24{byte_word[7]}}, byte_word[7:0]};
         OP_LBU: load_data = {24'h0, byte_word[7:0]};
         OP_LH: begin
            misalign  = addr[0];
            load_data = {{16{half_word[15]}}, half_word[15:0]};
         end
         OP_LHU: begin
            misalign  = addr[0];
            load_data = {16'h0, half_word[15:0]};
         end
         OP_LW: begin
            misalign  = (addr != 2'b00);
            load_data = rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: drives the data-memory handshake, stalls AGEX on
// outstanding accesses, forwards results. Optional macro MEM_STALL_CNT_EN.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DBITS          = 32,
   parameter int DMEM_ADDR_BITS = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [AGEX_LATCH_WIDTH-1:0]       from_AGEX_latch,
   output logic [MEM_LATCH_WIDTH-1:0]        MEM_latch_out,
   output logic [FROM_MEM_TO_AGEX_WIDTH-1:0] from_MEM_to_AGEX,
   output logic [FROM_MEM_TO_DE_WIDTH-1:0]   from_MEM_to_DE,
   output logic                              dmem_req_valid,
   input  logic                              dmem_req_ready,
   output logic                              dmem_we,
   output logic [DMEM_ADDR_BITS-1:0]         dmem_addr,
   output logic [DBITS-1:0]                  dmem_wdata,
   output logic [3:0]                        dmem_be,
   input  logic                              dmem_rsp_valid,
   input  logic [DBITS-1:0]                  dmem_rdata
`ifdef MEM_STALL_CNT_EN
   ,
   output logic [31:0]                       mem_stall_cycles
`endif
);

   agex_latch_t  agex;
   mem_latch_t   mem_latch_q, mem_latch_d;
   mem_to_agex_t to_agex;
   mem_to_de_t   to_de;
   mem_state_e   state_q, state_d;

   logic            op_load, op_store, op_mem;
   logic            misalign, mis_mem;
   logic [3:0]      be;
   logic [XLEN-1:0] wdata, load_data;
   logic            req_valid, stall, load_done;

   assign agex     = from_AGEX_latch;
   assign op_load  = is_load(agex.op);
   assign op_store = is_store(agex.op);
   assign op_mem   = op_load | op_store;
   assign mis_mem  = op_mem & misalign;

   mem_lane_align u_lane (
      .op         (agex.op),
      .addr       (agex.result[1:0]),
      .store_data (agex.store_data),
      .rdata      (dmem_rdata),
      .be         (be),
      .wdata      (wdata),
      .load_data  (load_data),
      .misalign   (misalign)
   );

   // Upstream is frozen by stall, so the request fields come straight from
   // the AGEX latch and remain stable through REQ and RSP.
   always_comb begin
      state_d   = state_q;
      req_valid = 1'b0;
      stall     = 1'b0;
      load_done = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (op_mem && !misalign) begin
               req_valid = 1'b1;
               if (!dmem_req_ready) begin
                  state_d = S_REQ;
                  stall   = 1'b1;
               end else if (op_load) begin
                  state_d = S_RSP;
                  stall   = 1'b1;
               end
            end
         end
         S_REQ: begin
            req_valid = 1'b1;
            if (!dmem_req_ready) begin
               stall = 1'b1;
            end else if (op_load) begin
               state_d = S_RSP;
               stall   = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RSP: begin
            if (dmem_rsp_valid) begin
               load_done = 1'b1;
               state_d   = S_IDLE;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_latch_d = '0;
      if (!stall) begin
         mem_latch_d.inst       = agex.inst;
         mem_latch_d.pc         = agex.pc;
         mem_latch_d.op         = agex.op;
         mem_latch_d.inst_count = agex.inst_count;
         mem_latch_d.reg_dest   = agex.reg_dest;
         mem_latch_d.wb_data    = load_done ? load_data : agex.result;
         mem_latch_d.wr_reg     = agex.wr_reg & ~mis_mem;
         mem_latch_d.misalign   = mis_mem;
         mem_latch_d.bus_canary = agex.bus_canary;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!reset) begin
         state_q     <= S_IDLE;
         mem_latch_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_latch_q <= mem_latch_d;
      end
   end

   always_comb begin
      to_agex.stall     = stall;
      to_agex.fwd_valid = (!op_load && agex.wr_reg) || load_done;
      to_agex.reg_dest  = agex.reg_dest;
      to_agex.fwd_data  = load_done ? load_data : agex.result;
      to_de.mem_busy    = (state_q != S_IDLE) || stall;
      to_de.reg_dest    = agex.reg_dest;
      to_de.wr_reg      = agex.wr_reg & ~mis_mem;
   end

   // Combinational outputs follow the AGEX latch, so force them low while
   // reset is held rather than waiting for upstream to clear.
   assign MEM_latch_out    = mem_latch_q;
   assign from_MEM_to_AGEX = reset ? to_agex : '0;
   assign from_MEM_to_DE   = reset ? to_de : '0;
   assign dmem_req_valid   = reset & req_valid;
   assign dmem_we          = dmem_req_valid & op_store;
   assign dmem_addr        = dmem_req_valid ? agex.result[DMEM_ADDR_BITS-1:0] : '0;
   assign dmem_wdata       = dmem_req_valid ? wdata : '0;
   assign dmem_be          = dmem_req_valid ? be : 4'b0000;

`ifdef MEM_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign mem_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-cycle ops plus
// hand-written load, held-store and reset-abandon sequences.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic                              clk = 1'b0;
   logic                              reset;
   agex_latch_t                       agex_in;
   logic [MEM_LATCH_WIDTH-1:0]        MEM_latch_out;
   logic [FROM_MEM_TO_AGEX_WIDTH-1:0] from_MEM_to_AGEX;
   logic [FROM_MEM_TO_DE_WIDTH-1:0]   from_MEM_to_DE;
   logic                              dmem_req_valid, dmem_req_ready, dmem_we;
   logic [15:0]                       dmem_addr;
   logic [31:0]                       dmem_wdata, dmem_rdata;
   logic [3:0]                        dmem_be;
   logic                              dmem_rsp_valid;
`ifdef MEM_STALL_CNT_EN
   logic [31:0]                       mem_stall_cycles;
`endif

   mem_latch_t   ml;
   mem_to_agex_t ta;
   mem_to_de_t   td;
   assign ml = MEM_latch_out;
   assign ta = from_MEM_to_AGEX;
   assign td = from_MEM_to_DE;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_stage #(.DBITS(32), .DMEM_ADDR_BITS(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .from_AGEX_latch  (agex_in),
      .MEM_latch_out    (MEM_latch_out),
      .from_MEM_to_AGEX (from_MEM_to_AGEX),
      .from_MEM_to_DE   (from_MEM_to_DE),
      .dmem_req_valid   (dmem_req_valid),
      .dmem_req_ready   (dmem_req_ready),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_wdata       (dmem_wdata),
      .dmem_be          (dmem_be),
      .dmem_rsp_valid   (dmem_rsp_valid),
      .dmem_rdata       (dmem_rdata)
`ifdef MEM_STALL_CNT_EN
      ,
      .mem_stall_cycles (mem_stall_cycles)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_op(input op_e op, input logic [31:0] result, input logic [31:0] sd,
                         input logic wr, input logic [4:0] dest);
      agex_in            = '0;
      agex_in.inst       = 32'h0BAD_0000 | {26'h0, op};
      agex_in.pc         = 32'h0000_4000 + {27'h0, dest, 2'b00};
      agex_in.op         = op;
      agex_in.inst_count = {27'h0, dest};
      agex_in.reg_dest   = dest;
      agex_in.result     = result;
      agex_in.store_data = sd;
      agex_in.wr_reg     = wr;
      agex_in.bus_canary = 8'hA5;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Load with ready=1 on first cycle and rsp_valid after rsp_wait RSP cycles.
   task automatic do_load(input string name, input op_e op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp, input int rsp_wait);
      int ns;
      ns = 0;
      set_op(op, addr, 32'h0, 1'b1, 5'd7);
      dmem_req_ready = 1'b1;
      dmem_rdata     = 32'hDEAD_BEEF;
      @(negedge clk);
      check({name, "_req_valid"}, {31'h0, dmem_req_valid}, 32'd1);
      check({name, "_addr"}, {16'h0, dmem_addr}, {16'h0, addr[15:0]});
      if (ta.stall) ns++;
      next_cycle();
      dmem_req_ready = 1'b0;
      check({name, "_bubble"}, ml.wb_data | {31'h0, ml.wr_reg}, 32'h0);
      for (int i = 0; i < rsp_wait; i++) begin
         @(negedge clk);
         if (ta.stall) ns++;
         check({name, "_busy_rsp"}, {31'h0, td.mem_busy}, 32'd1);
         next_cycle();
      end
      dmem_rsp_valid = 1'b1;
      dmem_rdata     = rdata;
      @(negedge clk);
      if (ta.stall) ns++;
      check({name, "_fwd_valid"}, {31'h0, ta.fwd_valid}, 32'd1);
      check({name, "_fwd_data"}, ta.fwd_data, exp);
      check({name, "_stall_cycles"}, ns, rsp_wait + 1);
      next_cycle();
      dmem_rsp_valid = 1'b0;
      dmem_rdata     = 32'hDEAD_BEEF;
      check({name, "_wb_data"}, ml.wb_data, exp);
      check({name, "_wr_reg"}, {31'h0, ml.wr_reg}, 32'd1);
      set_op(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
   endtask

   typedef struct {
      string       name;
      op_e         op;
      logic [31:0] result;
      logic [31:0] sd;
      logic        wr;
      logic        ready;
      logic        exp_req;
      logic        exp_fwd;
      logic [31:0] exp_fwd_data;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic        exp_wr;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{"add",     OP_ADD, 32'h5,         32'h0,         1, 1, 0, 1, 32'h5,         4'h0, 32'h0,         1, 0};
      vecs[1]  = '{"sub_nowr", OP_SUB, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0, 32'h0,         4'h0, 32'h0,         0, 0};
      vecs[2]  = '{"lw_mis",  OP_LW,  32'h101,       32'h0,         1, 1, 0, 0, 32'h0,         4'h0, 32'h0,         0, 1};
      vecs[3]  = '{"lh_mis",  OP_LH,  32'h103,       32'h0,         1, 1, 0, 0, 32'h0,         4'h0, 32'h0,         0, 1};
      vecs[4]  = '{"sw_mis",  OP_SW,  32'h102,       32'h11223344,  0, 1, 0, 0, 32'h0,         4'h0, 32'h0,         0, 1};
      vecs[5]  = '{"sh_mis",  OP_SH,  32'h101,       32'h5566,      0, 1, 0, 0, 32'h0,         4'h0, 32'h0,         0, 1};
      vecs[6]  = '{"sb_3",    OP_SB,  32'h103,       32'h000000A5,  0, 1, 1, 0, 32'h0,         4'h8, 32'hA5A5A5A5,  0, 0};
      vecs[7]  = '{"sh_2",    OP_SH,  32'h102,       32'hFFFF1234,  0, 1, 1, 0, 32'h0,         4'hC, 32'h12341234,  0, 0};
      vecs[8]  = '{"sw_0",    OP_SW,  32'h200,       32'hCAFEF00D,  0, 1, 1, 0, 32'h0,         4'hF, 32'hCAFEF00D,  0, 0};
      vecs[9]  = '{"sb_0",    OP_SB,  32'h100,       32'h0000003C,  0, 1, 1, 0, 32'h0,         4'h1, 32'h3C3C3C3C,  0, 0};
      vecs[10] = '{"lhu_mis", OP_LHU, 32'h105,       32'h0,         1, 0, 0, 0, 32'h0,         4'h0, 32'h0,         0, 1};
      vecs[11] = '{"or_zero", OP_OR,  32'h0,         32'h0,         1, 0, 0, 1, 32'h0,         4'h0, 32'h0,         1, 0};

      // Reset with a live op at the input: every output must read zero.
      reset          = 1'b0;
      dmem_req_ready = 1'b1;
      dmem_rsp_valid = 1'b0;
      dmem_rdata     = 32'h0;
      set_op(OP_SW, 32'h100, 32'h1, 1'b1, 5'd3);
      #1;
      check("rst_latch_zero", {31'h0, MEM_latch_out != '0}, 32'd0);
      check("rst_req_valid", {31'h0, dmem_req_valid}, 32'd0);
      check("rst_to_agex_zero", {31'h0, from_MEM_to_AGEX != '0}, 32'd0);
      check("rst_to_de_zero", {31'h0, from_MEM_to_DE != '0}, 32'd0);
      set_op(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
      repeat (2) next_cycle();
      reset = 1'b1;
      next_cycle();

      // Single-cycle ops; rsp_valid held high to show it is ignored in IDLE.
      foreach (vecs[i]) begin
         set_op(vecs[i].op, vecs[i].result, vecs[i].sd, vecs[i].wr, 5'(i + 1));
         dmem_req_ready = vecs[i].ready;
         dmem_rsp_valid = 1'b1;
         @(negedge clk);
         check({vecs[i].name, "_req_valid"}, {31'h0, dmem_req_valid}, {31'h0, vecs[i].exp_req});
         check({vecs[i].name, "_stall"}, {31'h0, ta.stall}, 32'd0);
         check({vecs[i].name, "_fwd_valid"}, {31'h0, ta.fwd_valid}, {31'h0, vecs[i].exp_fwd});
         if (vecs[i].exp_fwd)
            check({vecs[i].name, "_fwd_data"}, ta.fwd_data, vecs[i].exp_fwd_data);
         if (vecs[i].exp_req) begin
            check({vecs[i].name, "_be"}, {28'h0, dmem_be}, {28'h0, vecs[i].exp_be});
            check({vecs[i].name, "_wdata"}, dmem_wdata, vecs[i].exp_wdata);
            check({vecs[i].name, "_we"}, {31'h0, dmem_we}, 32'd1);
         end
         next_cycle();
         check({vecs[i].name, "_wb_data"}, ml.wb_data, vecs[i].result);
         check({vecs[i].name, "_wr_reg"}, {31'h0, ml.wr_reg}, {31'h0, vecs[i].exp_wr});
         check({vecs[i].name, "_misalign"}, {31'h0, ml.misalign}, {31'h0, vecs[i].exp_mis});
         check({vecs[i].name, "_reg_dest"}, {27'h0, ml.reg_dest}, i + 1);
      end
      check("canary_pass", {24'h0, ml.bus_canary}, 32'hA5);
      dmem_rsp_valid = 1'b0;
      set_op(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
      next_cycle();

      // Signed byte load, two empty RSP cycles: three stall cycles total.
      do_load("lb_103", OP_LB, 32'h103, 32'h80FFFFFF, 32'hFFFFFF80, 2);
`ifdef MEM_STALL_CNT_EN
      check("stall_counter", mem_stall_cycles, 32'd3);
`endif
      do_load("lbu_103", OP_LBU, 32'h103, 32'h80FFFFFF, 32'h00000080, 0);
      do_load("lb_101",  OP_LB,  32'h101, 32'h00007F00, 32'h0000007F, 1);
      do_load("lh_102",  OP_LH,  32'h102, 32'h80017FFF, 32'hFFFF8001, 0);
      do_load("lhu_100", OP_LHU, 32'h100, 32'h80017FFF, 32'h00007FFF, 0);
      do_load("lw_104",  OP_LW,  32'h104, 32'h12345678, 32'h12345678, 1);

      // Store held in REQ for three cycles of ready low.
      set_op(OP_SH, 32'h102, 32'h1234, 1'b0, 5'd4);
      dmem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) dmem_req_ready = 1'b1;
         @(negedge clk);
         check("sh_hold_valid", {31'h0, dmem_req_valid}, 32'd1);
         check("sh_hold_be", {28'h0, dmem_be}, 32'hC);
         check("sh_hold_wdata", dmem_wdata, 32'h12341234);
         check("sh_hold_addr", {16'h0, dmem_addr}, 32'h102);
         check("sh_hold_stall", {31'h0, ta.stall}, {31'h0, (i < 3)});
         next_cycle();
      end
      dmem_req_ready = 1'b0;
      set_op(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0);
      check("sh_wb_data", ml.wb_data, 32'h102);
      check("sh_reg_dest", {27'h0, ml.reg_dest}, 32'd4);
      @(negedge clk);
      check("sh_idle_busy", {31'h0, td.mem_busy}, 32'd0);
      check("sh_idle_valid", {31'h0, dmem_req_valid}, 32'd0);
      next_cycle();

      // Reset while waiting in RSP; a late response must be ignored.
      set_op(OP_LW, 32'h100, 32'h0, 1'b1, 5'd9);
      dmem_req_ready = 1'b1;
      next_cycle();
      dmem_req_ready = 1'b0;
      @(negedge clk);
      check("rr_busy_rsp", {31'h0, td.mem_busy}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("rr_async_latch", {31'h0, MEM_latch_out != '0}, 32'd0);
      check("rr_async_to_agex", {31'h0, from_MEM_to_AGEX != '0}, 32'd0);
      check("rr_async_valid", {31'h0, dmem_req_valid}, 32'd0);
      agex_in = '0;
      next_cycle();
      reset = 1'b1;
      next_cycle();
      dmem_rsp_valid = 1'b1;
      dmem_rdata     = 32'h55555555;
      @(negedge clk);
      check("rr_late_fwd", {31'h0, ta.fwd_valid}, 32'd0);
      check("rr_late_busy", {31'h0, td.mem_busy}, 32'd0);
      next_cycle();
      dmem_rsp_valid = 1'b0;
      check("rr_latch_zero", {31'h0, MEM_latch_out != '0}, 32'd0);
      set_op(OP_ADD, 32'h77, 32'h0, 1'b1, 5'd2);
      @(negedge clk);
      check("rr_after_stall", {31'h0, ta.stall}, 32'd0);
      next_cycle();
      check("rr_after_wb", ml.wb_data, 32'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
